// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, ALUOp encodings and funct field constants
package alu_pkg;

   localparam logic [2:0] CTRL_AND = 3'b000;
   localparam logic [2:0] CTRL_XOR = 3'b001;
   localparam logic [2:0] CTRL_SLL = 3'b010;
   localparam logic [2:0] CTRL_ADD = 3'b011;
   localparam logic [2:0] CTRL_SUB = 3'b100;
   localparam logic [2:0] CTRL_MUL = 3'b101;
   localparam logic [2:0] CTRL_SRA = 3'b110;
   localparam logic [2:0] CTRL_NOP = 3'b111;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SR  = 3'b101;
   localparam logic [2:0] F3_AND = 3'b111;

   typedef struct packed {
      logic [2:0] ctrl;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// rtl/alu_ctrl_stage_if.sv - decode-side and EX-side handshake bundle of the ALU control stage
interface alu_ctrl_stage_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
);
   logic              valid_i;
   logic              ready_o;
   logic [1:0]        ALUOp_i;
   logic [6:0]        funct7_i;
   logic [2:0]        funct3_i;
   logic              ALUSrc_i;
   logic [DATA_W-1:0] rs1_data_i;
   logic [DATA_W-1:0] rs2_data_i;
   logic [DATA_W-1:0] imm_i;
   logic              flush_i;
   logic              valid_o;
   logic              ready_i;
   logic [2:0]        ALUCtrl_o;
   logic [DATA_W-1:0] data1_o;
   logic [DATA_W-1:0] data2_o;
   logic              illegal_o;
   logic [CNT_W-1:0]  illegal_cnt_o;

   modport slave (
      input  valid_i, ALUOp_i, funct7_i, funct3_i, ALUSrc_i,
             rs1_data_i, rs2_data_i, imm_i, flush_i, ready_i,
      output ready_o, valid_o, ALUCtrl_o, data1_o, data2_o,
             illegal_o, illegal_cnt_o
   );

   modport master (
      output valid_i, ALUOp_i, funct7_i, funct3_i, ALUSrc_i,
             rs1_data_i, rs2_data_i, imm_i, flush_i, ready_i,
      input  ready_o, valid_o, ALUCtrl_o, data1_o, data2_o,
             illegal_o, illegal_cnt_o
   );
endinterface

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational ALUOp/funct7/funct3 to ALU control code decoder
module alu_ctrl_dec
   import alu_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [6:0] funct7_i,
   input  logic [2:0] funct3_i,
   output dec_t       dec_o
);

   always_comb begin
      dec_o = '{ctrl: CTRL_NOP, illegal: 1'b1};
      case (alu_op_i)
         ALUOP_MEM: dec_o = '{ctrl: CTRL_ADD, illegal: 1'b0};
         ALUOP_BR:  dec_o = '{ctrl: CTRL_SUB, illegal: 1'b0};
         ALUOP_R: begin
            case ({funct7_i, funct3_i})
               {F7_BASE, F3_AND}: dec_o = '{ctrl: CTRL_AND, illegal: 1'b0};
               {F7_BASE, F3_XOR}: dec_o = '{ctrl: CTRL_XOR, illegal: 1'b0};
               {F7_BASE, F3_SLL}: dec_o = '{ctrl: CTRL_SLL, illegal: 1'b0};
               {F7_BASE, F3_ADD}: dec_o = '{ctrl: CTRL_ADD, illegal: 1'b0};
               {F7_ALT,  F3_ADD}: dec_o = '{ctrl: CTRL_SUB, illegal: 1'b0};
               {F7_MUL,  F3_ADD}: dec_o = '{ctrl: CTRL_MUL, illegal: 1'b0};
               default:           dec_o = '{ctrl: CTRL_NOP, illegal: 1'b1};
            endcase
         end
         ALUOP_I: begin
            // addi ignores funct7 because those bits belong to the immediate
            if (funct3_i == F3_ADD) begin
               dec_o = '{ctrl: CTRL_ADD, illegal: 1'b0};
            end else if (funct3_i == F3_SR && funct7_i == F7_ALT) begin
               dec_o = '{ctrl: CTRL_SRA, illegal: 1'b0};
            end
         end
         default: dec_o = '{ctrl: CTRL_NOP, illegal: 1'b1};
      endcase
   end

endmodule

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - ALU op decode, operand select and ID/EX issue register with flush and illegal-op count
module alu_ctrl_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   alu_ctrl_stage_if.slave   bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   dec_t              dec;
   logic              ready;
   logic              accept;
   logic              valid_q,   valid_d;
   logic              illegal_q, illegal_d;
   logic [2:0]        ctrl_q,    ctrl_d;
   logic [DATA_W-1:0] data1_q,   data1_d;
   logic [DATA_W-1:0] data2_q,   data2_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;

   alu_ctrl_dec u_dec (
      .alu_op_i (bus.ALUOp_i),
      .funct7_i (bus.funct7_i),
      .funct3_i (bus.funct3_i),
      .dec_o    (dec)
   );

   assign ready  = !valid_q || bus.ready_i;
   assign accept = bus.valid_i && ready && !bus.flush_i;

   always_comb begin
      valid_d   = valid_q;
      illegal_d = illegal_q;
      ctrl_d    = ctrl_q;
      data1_d   = data1_q;
      data2_d   = data2_q;
      cnt_d     = cnt_q;
      if (bus.flush_i) begin
         valid_d   = 1'b0;
         illegal_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         illegal_d = dec.illegal;
         ctrl_d    = dec.ctrl;
         data1_d   = bus.rs1_data_i;
         data2_d   = bus.ALUSrc_i ? bus.imm_i : bus.rs2_data_i;
      end else if (bus.ready_i) begin
         valid_d   = 1'b0;
         illegal_d = 1'b0;
      end
      // counter survives flush; only accepted illegal ops advance it
      if (accept && dec.illegal && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         ctrl_q    <= CTRL_NOP;
         data1_q   <= '0;
         data2_q   <= '0;
         cnt_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         ctrl_q    <= ctrl_d;
         data1_q   <= data1_d;
         data2_q   <= data2_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.ready_o       = ready;
   assign bus.valid_o       = valid_q;
   assign bus.illegal_o     = illegal_q;
   assign bus.ALUCtrl_o     = ctrl_q;
   assign bus.data1_o       = data1_q;
   assign bus.data2_o       = data2_q;
   assign bus.illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - self-checking bench for alu_ctrl_stage with an 8-bit and a 2-bit counter instance
module tb_alu_ctrl_stage;

   typedef struct {
      logic        v;
      logic [1:0]  op;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic        src;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        fl;
      logic        rdy;
      logic [2:0]  ec;
      logic        ei;
   } vec_t;

   typedef struct {
      logic [2:0]  ctrl;
      logic        ill;
      logic [31:0] d1;
      logic [31:0] d2;
   } exp_t;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk = ~clk;

   alu_ctrl_stage_if #(.DATA_W(32), .CNT_W(8)) bus ();
   alu_ctrl_stage_if #(.DATA_W(32), .CNT_W(2)) sbus ();

   assign sbus.valid_i    = bus.valid_i;
   assign sbus.ALUOp_i    = bus.ALUOp_i;
   assign sbus.funct7_i   = bus.funct7_i;
   assign sbus.funct3_i   = bus.funct3_i;
   assign sbus.ALUSrc_i   = bus.ALUSrc_i;
   assign sbus.rs1_data_i = bus.rs1_data_i;
   assign sbus.rs2_data_i = bus.rs2_data_i;
   assign sbus.imm_i      = bus.imm_i;
   assign sbus.flush_i    = bus.flush_i;
   assign sbus.ready_i    = bus.ready_i;

   alu_ctrl_stage #(.DATA_W(32), .CNT_W(8)) dut (.clk_i(clk), .rst_i(rst_i), .bus(bus));
   alu_ctrl_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (.clk_i(clk), .rst_i(rst_i), .bus(sbus));

   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];
   logic m_valid = 1'b0;
   logic m_flushed = 1'b0;
   int   m_cnt8 = 0;
   int   m_cnt2 = 0;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                               input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [2:0] ec, input logic ei);
      vec_t v;
      v.v = 1'b1; v.op = op; v.f7 = f7; v.f3 = f3; v.src = src;
      v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.fl = 1'b0; v.rdy = 1'b1;
      v.ec = ec; v.ei = ei;
      return v;
   endfunction

   function automatic vec_t idle(input logic rdy);
      vec_t v;
      v = mk(2'b00, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 3'b011, 1'b0);
      v.v = 1'b0;
      v.rdy = rdy;
      return v;
   endfunction

   function automatic vec_t with_rdy(input vec_t v, input logic rdy, input logic fl);
      vec_t r;
      r = v;
      r.rdy = rdy;
      r.fl = fl;
      return r;
   endfunction

   task automatic drive(input vec_t v);
      bus.valid_i    = v.v;
      bus.ALUOp_i    = v.op;
      bus.funct7_i   = v.f7;
      bus.funct3_i   = v.f3;
      bus.ALUSrc_i   = v.src;
      bus.rs1_data_i = v.rs1;
      bus.rs2_data_i = v.rs2;
      bus.imm_i      = v.imm;
      bus.flush_i    = v.fl;
      bus.ready_i    = v.rdy;
   endtask

   // one clock: check what the last edge produced, then predict the coming edge
   task automatic cycle(input vec_t v);
      logic accept;
      exp_t e;
      @(negedge clk);
      drive(v);
      #1;
      chk("ready_o", bus.ready_o, !m_valid || v.rdy);
      chk("valid_o", bus.valid_o, m_valid);
      chk("valid_o_sat", sbus.valid_o, m_valid);
      chk("cnt8", bus.illegal_cnt_o, m_cnt8);
      chk("cnt2", sbus.illegal_cnt_o, m_cnt2);
      if (m_flushed) chk("illegal_after_flush", bus.illegal_o, 1'b0);
      if (m_valid) begin
         if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_empty actual=valid required=no_entry t=%0t", $time);
         end else begin
            chk("ctrl", bus.ALUCtrl_o, sbq[0].ctrl);
            chk("illegal_o", bus.illegal_o, sbq[0].ill);
            chk("data1", bus.data1_o, sbq[0].d1);
            chk("data2", bus.data2_o, sbq[0].d2);
            if (v.rdy || v.fl) void'(sbq.pop_front());
         end
      end
      accept = v.v && (!m_valid || v.rdy) && !v.fl;
      if (accept) begin
         e.ctrl = v.ec; e.ill = v.ei; e.d1 = v.rs1; e.d2 = v.src ? v.imm : v.rs2;
         sbq.push_back(e);
         if (v.ei) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
      m_flushed = v.fl;
      m_valid = v.fl ? 1'b0 : accept ? 1'b1 : v.rdy ? 1'b0 : m_valid;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst_i = 1'b0;
      #1;
      chk("rst_valid", bus.valid_o, 1'b0);
      chk("rst_illegal", bus.illegal_o, 1'b0);
      chk("rst_ctrl", bus.ALUCtrl_o, 3'b111);
      chk("rst_data1", bus.data1_o, 32'd0);
      chk("rst_data2", bus.data2_o, 32'd0);
      chk("rst_cnt8", bus.illegal_cnt_o, 8'd0);
      chk("rst_cnt2", sbus.illegal_cnt_o, 2'd0);
      m_valid = 1'b0; m_flushed = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
      sbq.delete();
      drive(idle(1'b1));
      @(negedge clk);
      rst_i = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t add_op, sub_op, xor_op, bad_op;
      drive(idle(1'b1));

      tbl.push_back(mk(2'b10, 7'b0000000, 3'b111, 1'b0, 32'd7, 32'd3, 32'd0, 3'b000, 1'b0));
      tbl.push_back(mk(2'b10, 7'b0000000, 3'b100, 1'b0, 32'd7, 32'd3, 32'd0, 3'b001, 1'b0));
      tbl.push_back(mk(2'b10, 7'b0000000, 3'b001, 1'b0, 32'd7, 32'd3, 32'd0, 3'b010, 1'b0));
      tbl.push_back(mk(2'b10, 7'b0000000, 3'b000, 1'b0, 32'd7, 32'd3, 32'd0, 3'b011, 1'b0));
      tbl.push_back(mk(2'b10, 7'b0100000, 3'b000, 1'b0, 32'd7, 32'd3, 32'd0, 3'b100, 1'b0));
      tbl.push_back(mk(2'b10, 7'b0000001, 3'b000, 1'b0, 32'd7, 32'd3, 32'd0, 3'b101, 1'b0));
      tbl.push_back(mk(2'b00, 7'b1111111, 3'b010, 1'b1, 32'h100, 32'd9, 32'h10, 3'b011, 1'b0));
      tbl.push_back(mk(2'b01, 7'b0000000, 3'b001, 1'b0, 32'd20, 32'd20, 32'd8, 3'b100, 1'b0));
      tbl.push_back(mk(2'b11, 7'b1010101, 3'b000, 1'b1, 32'd1, 32'd2, 32'hFFFF_FFFC, 3'b011, 1'b0));
      tbl.push_back(mk(2'b11, 7'b0100000, 3'b101, 1'b1, 32'h8000_0000, 32'd3, 32'd5, 3'b110, 1'b0));
      tbl.push_back(mk(2'b11, 7'b0000000, 3'b101, 1'b1, 32'd7, 32'd3, 32'd5, 3'b111, 1'b1));
      tbl.push_back(mk(2'b10, 7'b0100000, 3'b111, 1'b0, 32'd7, 32'd3, 32'd0, 3'b111, 1'b1));
      tbl.push_back(mk(2'b10, 7'b0000001, 3'b001, 1'b0, 32'd7, 32'd3, 32'd0, 3'b111, 1'b1));
      tbl.push_back(mk(2'b11, 7'b0000000, 3'b010, 1'b0, 32'd7, 32'd3, 32'd0, 3'b111, 1'b1));

      do_reset();

      // back-to-back sweep at full throughput
      for (int i = 0; i < tbl.size(); i++) cycle(tbl[i]);
      cycle(idle(1'b1));
      cycle(idle(1'b1));

      // stall: ADD held for 3 cycles while SUB waits
      add_op = tbl[3];
      sub_op = tbl[4];
      xor_op = tbl[1];
      cycle(add_op);
      for (int i = 0; i < 3; i++) cycle(with_rdy(sub_op, 1'b0, 1'b0));
      cycle(sub_op);
      cycle(idle(1'b1));
      cycle(idle(1'b1));

      // flush with an offered op and a held entry
      cycle(add_op);
      cycle(with_rdy(xor_op, 1'b0, 1'b1));
      cycle(idle(1'b1));
      cycle(add_op);
      cycle(with_rdy(xor_op, 1'b1, 1'b1));
      cycle(idle(1'b1));

      // flush during a stall
      cycle(add_op);
      cycle(idle(1'b0));
      cycle(idle(1'b0));
      cycle(with_rdy(idle(1'b0), 1'b0, 1'b1));
      cycle(idle(1'b0));
      cycle(idle(1'b1));

      // reset while stalled discards the held entry
      cycle(add_op);
      cycle(idle(1'b0));
      do_reset();
      cycle(idle(1'b1));
      cycle(idle(1'b1));

      // saturation: 2-bit counter reads 1,2,3,3,3
      bad_op = tbl[10];
      for (int i = 0; i < 5; i++) cycle(bad_op);
      cycle(idle(1'b1));
      chk("sat_cnt2_final", sbus.illegal_cnt_o, 2'd3);
      chk("sat_cnt8_final", bus.illegal_cnt_o, 8'd5);

      // mixed traffic with random backpressure and occasional flush
      for (int i = 0; i < 60; i++) begin
         vec_t r;
         r = tbl[$urandom_range(0, tbl.size() - 1)];
         r.v = ($urandom_range(0, 3) != 0);
         r.rdy = ($urandom_range(0, 2) != 0);
         r.fl = ($urandom_range(0, 9) == 0);
         r.rs1 = $urandom;
         r.rs2 = $urandom;
         r.imm = $urandom;
         cycle(r);
      end
      for (int i = 0; i < 3; i++) cycle(idle(1'b1));
      chk("sb_drained", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
